// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues sequential reads to instruction memory under
// a credit limit and queues returning words with their PCs for decode.
module fetch_buffer #(
    parameter int                AWIDTH         = 32,
    parameter int                DWIDTH         = 32,
    parameter logic [AWIDTH-1:0] IMEM_BASE_ADDR = 32'h01000000,
    parameter int                DEPTH          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [AWIDTH-1:0]          imem_addr_o,
    output logic                       imem_read_en_o,
    input  logic [DWIDTH-1:0]          imem_rdata_i,
    input  logic                       redirect_i,
    input  logic [AWIDTH-1:0]          redirect_pc_i,
    output logic                       insn_valid_o,
    input  logic                       insn_ready_i,
    output logic [DWIDTH-1:0]          insn_o,
    output logic [AWIDTH-1:0]          pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [AWIDTH-1:0] fpc_q, fpc_d;
    logic              inflight_q, inflight_d;
    logic [AWIDTH-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [DWIDTH-1:0] data_mem [DEPTH];
    logic [AWIDTH-1:0] pc_mem   [DEPTH];

    logic [CW:0]       credit_used;
    logic              req;
    logic              push;
    logic              pop;

    // Credit check and per-cycle event decode; redirect and reset kill everything.
    always_comb begin
        credit_used = {1'b0, count_q} + (CW+1)'(inflight_q);
        req         = rst && !redirect_i && (credit_used < (CW+1)'(DEPTH));
        push        = rst && !redirect_i && inflight_q;
        pop         = rst && !redirect_i && (count_q != '0) && insn_ready_i;
    end

    // Next-state for fetch PC, in-flight tracking and queue pointers.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        fpc_d      = fpc_q;
        inflight_d = req;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            fpc_d      = {redirect_pc_i[AWIDTH-1:2], 2'b00};
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req) begin
                fpc_d    = fpc_q + AWIDTH'(4);
                req_pc_d = fpc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            fpc_q      <= IMEM_BASE_ADDR;
            inflight_q <= 1'b0;
            req_pc_q   <= IMEM_BASE_ADDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage: write returning word and its request PC at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; outputs are masked by count_q so stale contents never leak.
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign imem_addr_o    = fpc_q;
    assign imem_read_en_o = req;
    assign insn_valid_o   = (count_q != '0);
    assign insn_o         = insn_valid_o ? data_mem[rd_ptr_q] : '0;
    assign pc_o           = insn_valid_o ? pc_mem[rd_ptr_q]   : '0;
    assign count_o        = count_q;

    no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count_q == CW'(DEPTH))));

endmodule
